// File: rtl/stream_tracker.sv
// stream_tracker: per-channel request/response tag scoreboard for CCI-P traffic.
// Each channel keeps a table of outstanding tags with their header metadata.
// A matching response retires a tag. Orphan responses, duplicate tags, table
// overflow and stale entries are reported on a registered one-cycle error port.
// Optional: define STREAM_TRACKER_DISPLAY_EN for simulation-only error printing
// and an end-of-run dump of still-outstanding tags.

`ifndef CCIP_TX_HDR_WIDTH
`define CCIP_TX_HDR_WIDTH 74
`endif

module stream_tracker #(
    parameter int NUM_CH      = 2,
    parameter int DEPTH       = 64,
    parameter int TID_WIDTH   = 16,
    parameter int META_WIDTH  = `CCIP_TX_HDR_WIDTH,
    parameter int TIMEOUT_CYC = 4096,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_CH-1:0]            i_req_valid,
    input  logic [NUM_CH*TID_WIDTH-1:0]  i_req_tid,
    input  logic [NUM_CH*META_WIDTH-1:0] i_req_meta,
    input  logic [NUM_CH-1:0]            i_rsp_valid,
    input  logic [NUM_CH*TID_WIDTH-1:0]  i_rsp_tid,
    output logic [NUM_CH*CNT_W-1:0]      o_outstanding,
    output logic [NUM_CH-1:0]            o_full,
    output logic                         o_err_valid,
    output logic [2:0]                   o_err_code,
    output logic [CH_W-1:0]              o_err_chan,
    output logic [TID_WIDTH-1:0]         o_err_tid,
    output logic [META_WIDTH-1:0]        o_err_meta,
    output logic [4*NUM_CH-1:0]          o_err_sticky
);
    localparam int IDX_W = $clog2(DEPTH);
    // Age counter only needs to reach TIMEOUT_CYC; keep one bit when timeout is off.
    localparam int AGE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_TO  = AGE_W'(TIMEOUT_CYC);
    localparam logic [2:0] CODE_OVF  = 3'd1;
    localparam logic [2:0] CODE_DUP  = 3'd2;
    localparam logic [2:0] CODE_ORPH = 3'd3;
    localparam logic [2:0] CODE_TO   = 3'd4;

    function automatic logic [AGE_W-1:0] f_age_inc(input logic [AGE_W-1:0] age);
        return (age == AGE_MAX) ? age : age + AGE_W'(1);
    endfunction

    // Table state
    logic [DEPTH-1:0]      r_vld  [NUM_CH];
    logic [DEPTH-1:0]      r_rep  [NUM_CH];
    logic [AGE_W-1:0]      r_age  [NUM_CH][DEPTH];
    logic [TID_WIDTH-1:0]  r_tid  [NUM_CH][DEPTH];
    logic [META_WIDTH-1:0] r_meta [NUM_CH][DEPTH];
    logic [CNT_W-1:0]      r_cnt  [NUM_CH];
    logic [NUM_CH-1:0]     r_full;

    // Error outputs
    logic                  r_err_valid;
    logic [2:0]            r_err_code;
    logic [CH_W-1:0]       r_err_chan;
    logic [TID_WIDTH-1:0]  r_err_tid;
    logic [META_WIDTH-1:0] r_err_meta;
    logic [4*NUM_CH-1:0]   r_sticky;

    // Per-channel lookup results
    logic [TID_WIDTH-1:0]  w_req_tid  [NUM_CH];
    logic [TID_WIDTH-1:0]  w_rsp_tid  [NUM_CH];
    logic [META_WIDTH-1:0] w_req_meta [NUM_CH];
    logic [NUM_CH-1:0]     w_rsp_hit, w_dup_hit, w_free, w_to_any;
    logic [IDX_W-1:0]      w_rsp_idx [NUM_CH];
    logic [IDX_W-1:0]      w_dup_idx [NUM_CH];
    logic [IDX_W-1:0]      w_alloc_idx [NUM_CH];
    logic [IDX_W-1:0]      w_to_idx [NUM_CH];
    logic [NUM_CH-1:0]     w_ovf, w_dup, w_orph, w_alloc, w_ret;
    logic [CNT_W-1:0]      w_cnt_nxt [NUM_CH];
    logic [4*NUM_CH-1:0]   w_flags;

    // Winning error for this cycle
    logic                  w_err_any;
    logic [2:0]            w_err_code;
    logic [CH_W-1:0]       w_err_chan;
    logic [TID_WIDTH-1:0]  w_err_tid;
    logic [META_WIDTH-1:0] w_err_meta;
    logic [NUM_CH-1:0]     w_to_ack;

    // Search every channel's table as it stood at the start of the cycle
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_req_tid[c]   = i_req_tid[c*TID_WIDTH +: TID_WIDTH];
            w_rsp_tid[c]   = i_rsp_tid[c*TID_WIDTH +: TID_WIDTH];
            w_req_meta[c]  = i_req_meta[c*META_WIDTH +: META_WIDTH];
            w_rsp_hit[c]   = 1'b0;
            w_dup_hit[c]   = 1'b0;
            w_free[c]      = 1'b0;
            w_to_any[c]    = 1'b0;
            w_rsp_idx[c]   = '0;
            w_dup_idx[c]   = '0;
            w_alloc_idx[c] = '0;
            w_to_idx[c]    = '0;
            // Descending scan: the last match written is the lowest index.
            for (int e = DEPTH - 1; e >= 0; e--) begin
                if (r_vld[c][e] && (r_tid[c][e] == w_rsp_tid[c])) begin
                    w_rsp_hit[c] = 1'b1;
                    w_rsp_idx[c] = IDX_W'(e);
                end
                if (r_vld[c][e] && (r_tid[c][e] == w_req_tid[c])) begin
                    w_dup_hit[c] = 1'b1;
                    w_dup_idx[c] = IDX_W'(e);
                end
                if (!r_vld[c][e]) begin
                    w_free[c]      = 1'b1;
                    w_alloc_idx[c] = IDX_W'(e);
                end
                if ((TIMEOUT_CYC != 0) && r_vld[c][e] && !r_rep[c][e] &&
                    (f_age_inc(r_age[c][e]) >= AGE_TO)) begin
                    w_to_any[c] = 1'b1;
                    w_to_idx[c] = IDX_W'(e);
                end
            end
            w_dup[c]   = i_req_valid[c] && w_dup_hit[c];
            w_ovf[c]   = i_req_valid[c] && !w_dup_hit[c] && !w_free[c];
            w_alloc[c] = i_req_valid[c] && !w_dup_hit[c] && w_free[c];
            w_orph[c]  = i_rsp_valid[c] && !w_rsp_hit[c];
            w_ret[c]   = i_rsp_valid[c] && w_rsp_hit[c];
            w_cnt_nxt[c] = r_cnt[c] + CNT_W'(w_alloc[c]) - CNT_W'(w_ret[c]);
            w_flags[c*4 +: 4] = {w_to_any[c], w_orph[c], w_dup[c], w_ovf[c]};
        end
    end

    // Pick one error: lowest channel, then overflow > duplicate > orphan > timeout
    always_comb begin
        w_err_any  = 1'b0;
        w_err_code = '0;
        w_err_chan = '0;
        w_err_tid  = '0;
        w_err_meta = '0;
        w_to_ack   = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_flags[c*4 +: 4] != 4'b0000) begin
                w_err_any  = 1'b1;
                w_err_chan = CH_W'(c);
                w_err_meta = '0;
                w_to_ack   = '0;
                if (w_ovf[c]) begin
                    w_err_code = CODE_OVF;
                    w_err_tid  = w_req_tid[c];
                end else if (w_dup[c]) begin
                    w_err_code = CODE_DUP;
                    w_err_tid  = w_req_tid[c];
                    w_err_meta = r_meta[c][w_dup_idx[c]];
                end else if (w_orph[c]) begin
                    w_err_code = CODE_ORPH;
                    w_err_tid  = w_rsp_tid[c];
                end else begin
                    w_err_code  = CODE_TO;
                    w_err_tid   = r_tid[c][w_to_idx[c]];
                    w_err_meta  = r_meta[c][w_to_idx[c]];
                    w_to_ack[c] = 1'b1;
                end
            end
        end
    end

    // Entry control, counters and error registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_vld[c] <= '0;
                r_rep[c] <= '0;
                r_cnt[c] <= '0;
                for (int e = 0; e < DEPTH; e++) r_age[c][e] <= '0;
            end
            r_full      <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
            r_err_chan  <= '0;
            r_err_tid   <= '0;
            r_err_meta  <= '0;
            r_sticky    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c]  <= w_cnt_nxt[c];
                r_full[c] <= (w_cnt_nxt[c] == CNT_W'(DEPTH));
                for (int e = 0; e < DEPTH; e++) begin
                    if (w_ret[c] && (w_rsp_idx[c] == IDX_W'(e))) begin
                        r_vld[c][e] <= 1'b0;
                    end else if (w_alloc[c] && (w_alloc_idx[c] == IDX_W'(e))) begin
                        r_vld[c][e] <= 1'b1;
                        r_age[c][e] <= '0;
                        r_rep[c][e] <= 1'b0;
                    end else if (r_vld[c][e]) begin
                        r_age[c][e] <= f_age_inc(r_age[c][e]);
                        if (w_to_ack[c] && (w_to_idx[c] == IDX_W'(e))) r_rep[c][e] <= 1'b1;
                    end
                end
            end
            r_err_valid <= w_err_any;
            r_err_code  <= w_err_code;
            r_err_chan  <= w_err_chan;
            r_err_tid   <= w_err_tid;
            r_err_meta  <= w_err_meta;
            r_sticky    <= r_sticky | w_flags;
        end
    end

    // Tag and header payload captured on allocation (no reset needed)
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_alloc[c] && (w_alloc_idx[c] == IDX_W'(e))) begin
                    r_tid[c][e]  <= w_req_tid[c];
                    r_meta[c][e] <= w_req_meta[c];
                end
            end
        end
    end

    // Flatten per-channel counters onto the output bus
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) o_outstanding[c*CNT_W +: CNT_W] = r_cnt[c];
    end

    assign o_full       = r_full;
    assign o_err_valid  = r_err_valid;
    assign o_err_code   = r_err_code;
    assign o_err_chan   = r_err_chan;
    assign o_err_tid    = r_err_tid;
    assign o_err_meta   = r_err_meta;
    assign o_err_sticky = r_sticky;

`ifdef STREAM_TRACKER_DISPLAY_EN
`ifndef BEGIN_RED_FONTCOLOR
`define BEGIN_RED_FONTCOLOR $display("\033[1;31m");
`endif
`ifndef END_RED_FONTCOLOR
`define END_RED_FONTCOLOR $display("\033[0m");
`endif
    function automatic string f_code_name(input logic [2:0] code);
        case (code)
            CODE_OVF:  return "OVERFLOW";
            CODE_DUP:  return "DUPLICATE";
            CODE_ORPH: return "ORPHAN";
            CODE_TO:   return "TIMEOUT";
            default:   return "UNKNOWN";
        endcase
    endfunction

    // Print each reported error as it is presented on the port
    always @(posedge i_clk) begin
        if (r_err_valid) begin
            `BEGIN_RED_FONTCOLOR
            $display("%m @%0t: %s chan=%0d tid=0x%0h meta=0x%0h",
                     $time, f_code_name(r_err_code), r_err_chan, r_err_tid, r_err_meta);
            `END_RED_FONTCOLOR
        end
    end

    final begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (r_vld[c][e]) $display("%m: chan %0d still outstanding tid=0x%0h", c, r_tid[c][e]);
            end
        end
    end
`endif

endmodule

// File: doc/stream_tracker.md
Name: stream_tracker

Overview:
- Parametrised multi-channel request/response scoreboard for ASE CCI-P traffic.
- Sits beside the TX/RX paths and records every issued request tag (tid plus header metadata) in a bounded per-channel table.
- Retires the entry when the matching response returns.
- Flags orphan responses, duplicate tags, table overflow and stale (timed-out) requests through registered error ports.

Parameters:
- NUM_CH, 2, number of independent request/response channels.
- DEPTH, 64, table entries per channel (power of 2 not required, >=2).
- TID_WIDTH, 16, tag width.
- META_WIDTH, CCIP_TX_HDR_WIDTH, stored header width.
- TIMEOUT_CYC, 4096, age at which an outstanding entry is reported stale; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_CH  request issued on channel c (bit c)
- req_tid  in  NUM_CH*TID_WIDTH  request tag, channel c at slice c
- req_meta  in  NUM_CH*META_WIDTH  request header, stored with tag
- rsp_valid  in  NUM_CH  response returned on channel c
- rsp_tid  in  NUM_CH*TID_WIDTH  response tag
- outstanding  out  NUM_CH*($clog2(DEPTH+1))  live entry count per channel
- full  out  NUM_CH  channel table has DEPTH live entries
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  1=overflow 2=duplicate 3=orphan 4=timeout
- err_chan  out  $clog2(NUM_CH) (min 1)  channel of reported error
- err_tid  out  TID_WIDTH  tag of reported error
- err_meta  out  META_WIDTH  stored meta for dup/timeout, else 0
- err_sticky  out  4*NUM_CH  per-channel sticky flags {timeout,orphan,dup,overflow}

Behaviour:
- Reset (rst_n low, async): all entries invalid, ages 0, outstanding=0, full=0, err_valid=0, err_code=0, err_chan=0, err_tid=0, err_meta=0, err_sticky=0. Reset mid-traffic discards all state; no errors raised for dropped entries.
- Entry: valid bit, tid, meta, age counter (width $clog2(TIMEOUT_CYC+1), saturating), reported bit.
- All lookups and decisions each cycle use table state registered at the start of the cycle; updates take effect next edge.
- Response, rsp_valid[c]:
  - Search channel c for a valid entry with equal tid.
  - Hit: clear that entry.
  - Miss: orphan error; table unchanged.
  - A response whose tag is issued in the same cycle is an orphan.
- Request, req_valid[c]:
  - Valid entry with equal tid already present: duplicate error; existing entry kept, new request not stored.
  - Else, table full at cycle start: overflow error; request dropped.
  - Else: allocate the lowest-index invalid entry; age=0, reported=0.
  - An entry freed by a response this cycle is not reusable until the next cycle.
- Same-cycle request and response with different tags on one channel: both processed; outstanding net unchanged.
- Age:
  - Every valid entry increments age each cycle, saturating.
  - When TIMEOUT_CYC!=0 and age reaches TIMEOUT_CYC with reported=0: timeout error, set reported. The entry stays live and can still be retired normally.
- Error reporting:
  - err_* registered, one cycle after the causing edge.
  - Multiple candidates in one cycle: lowest channel wins; within a channel, overflow > duplicate > orphan > timeout; among timeouts, lowest entry index.
  - Non-reported candidates still set their err_sticky bits. A timeout not reported (reported stays 0) is retried next cycle.
  - err_sticky clears only on reset.
- outstanding/full: registered, reflect table after the edge, so 1-cycle latency from req/rsp.
- Channels are fully independent; a tag may be live on several channels simultaneously.

Optional Feature:
- STREAM_TRACKER_DISPLAY_EN defined: on every err_valid, a simulation-only $display prints %m, $time, code name, channel, tid and meta in red font using the codebase colour macros. At the end of simulation (final block), prints each channel's still-outstanding tids.
- Undefined: no display or final code is compiled; port behaviour is identical.

Test Plan:
- Channel 0 issues tid 0x5 at cycle 10, responds 0x5 at cycle 20 -> outstanding[0]=1 on cycles 11-20, 0 from cycle 21, err_valid never asserted.
- Channel 1 response tid 0x9 with empty table -> err_valid=1, err_code=3, err_chan=1, err_tid=0x9 one cycle later; err_sticky orphan bit for ch1 set.
- DEPTH=4: issue tids 1,2,3,4 then 5 on ch0 -> full[0]=1 after the 4th; 5th gives err_code=1, err_tid=5; outstanding stays 4.
- Issue tid 0x7 on ch0 twice with different meta -> err_code=2, err_meta equals the first meta; outstanding=1.
- TIMEOUT_CYC=16: issue tid 0x3, no response -> err_code=4 exactly once, 16 cycles after entry was written. A later response 0x3 retires it with no error.
- Same cycle: ch0 duplicate and ch1 orphan -> reported err_chan=0, err_code=2; both sticky bits set. Assert rst_n low mid-burst -> all outputs 0 immediately.
